// File: rtl/mul_26x34_arb.sv
// Round-robin arbiter in front of a pipelined 26x34 unsigned multiplier.
// Results come back in issue order through a credit-protected FWFT FIFO.

module mul_26x34_rtl #(
    parameter int FF_IN  = 1,
    parameter int FF_MUL = 1,
    parameter int FF_OUT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [25:0] a_i,
    input  logic [33:0] b_i,
    output logic [59:0] c_o
);
    logic [25:0] a_s;
    logic [33:0] b_s;
    logic [59:0] p_s;
    logic [59:0] m_s;

    generate
        if (FF_IN != 0) begin : g_in
            logic [25:0] a_q;
            logic [33:0] b_q;
            // operand register stage
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= 26'd0;
                    b_q <= 34'd0;
                end else begin
                    a_q <= a_i;
                    b_q <= b_i;
                end
            end
            assign a_s = a_q;
            assign b_s = b_q;
        end else begin : g_in_comb
            assign a_s = a_i;
            assign b_s = b_i;
        end
    endgenerate

    assign p_s = {34'd0, a_s} * {26'd0, b_s};

    generate
        if (FF_MUL != 0) begin : g_mul
            logic [59:0] p_q;
            // product register stage
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    p_q <= 60'd0;
                end else begin
                    p_q <= p_s;
                end
            end
            assign m_s = p_q;
        end else begin : g_mul_comb
            assign m_s = p_s;
        end

        if (FF_OUT != 0) begin : g_out
            logic [59:0] c_q;
            // output register stage
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    c_q <= 60'd0;
                end else begin
                    c_q <= m_s;
                end
            end
            assign c_o = c_q;
        end else begin : g_out_comb
            assign c_o = m_s;
        end
    endgenerate
endmodule

module mul_26x34_arb_chk #(
    parameter int NREQ = 4
) (
    input logic            clk,
    input logic            rst_n,
    input logic            push_i,
    input logic            full_i,
    input logic [NREQ-1:0] req_ready_i
);
    a_no_overflow:  assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_i));
    a_ready_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready_i));
endmodule

module mul_26x34_arb #(
    parameter int NREQ   = 4,
    parameter int FF_IN  = 1,
    parameter int FF_MUL = 1,
    parameter int FF_OUT = 1,
    parameter int DEPTH  = 8,
    localparam int IDW   = (NREQ > 2) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*26-1:0] req_a,
    input  logic [NREQ*34-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [59:0]       rsp_c,
    output logic [3:0]        inflight
);
    localparam int LAT = FF_IN + FF_MUL + FF_OUT;
    localparam int AW  = 26;
    localparam int BW  = 34;
    localparam int RW  = 60;
    localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int NW  = $clog2(DEPTH + 1);
    localparam int SW  = (NW + 2 > 5) ? NW + 2 : 5;
    localparam int EW  = IDW + RW;

    generate
        if (LAT < 1 || DEPTH < LAT + 1) begin : g_bad_cfg
            $error("mul_26x34_arb: requires LAT >= 1 and DEPTH >= LAT+1");
        end
    endgenerate

    logic [IDW-1:0] last_grant_q;
    logic [IDW-1:0] grant_id_s;
    logic [IDW-1:0] hit_idx_s;
    logic           grant_any_s;
    logic           credit_s;
    logic           issue_s;
    logic [AW-1:0]  mul_a_q, mul_a_d;
    logic [BW-1:0]  mul_b_q, mul_b_d;
    logic [RW-1:0]  mul_c_s;
    logic           iss_vld_q;
    logic [IDW-1:0] iss_id_q;
    logic [LAT-1:0] vld_q;
    logic [IDW-1:0] id_q [LAT];
    logic [EW-1:0]  mem_q [DEPTH];
    logic [EW-1:0]  head_s;
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [NW-1:0]  cnt_q;
    logic [SW-1:0]  pipe_cnt_s, total_s;
    logic           push_s, pop_s, full_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? {PW{1'b0}} : p + PW'(1'b1);
    endfunction

    // round-robin search; iterating backwards lets the nearest requester win
    always_comb begin
        grant_id_s  = last_grant_q;
        grant_any_s = 1'b0;
        hit_idx_s   = last_grant_q;
        for (int i = NREQ; i >= 32'sd1; i--) begin
            hit_idx_s   = IDW'((int'(last_grant_q) + i) % NREQ);
            grant_id_s  = req_valid[hit_idx_s] ? hit_idx_s : grant_id_s;
            grant_any_s = grant_any_s | req_valid[hit_idx_s];
        end
    end

    assign total_s   = SW'(cnt_q) + pipe_cnt_s;
    assign credit_s  = (total_s < SW'(DEPTH));
    assign issue_s   = rst_n & credit_s & grant_any_s;
    assign req_ready = issue_s ? (NREQ'(1'b1) << grant_id_s) : {NREQ{1'b0}};

    // operand mux; idle cycles feed zeros to the multiplier
    always_comb begin
        mul_a_d = {AW{1'b0}};
        mul_b_d = {BW{1'b0}};
        for (int r = 0; r < NREQ; r++) begin
            mul_a_d = (issue_s && grant_id_s == IDW'(r)) ? req_a[AW*r +: AW] : mul_a_d;
            mul_b_d = (issue_s && grant_id_s == IDW'(r)) ? req_b[BW*r +: BW] : mul_b_d;
        end
    end

    // issue stage: operand registers, tag and arbitration pointer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mul_a_q      <= {AW{1'b0}};
            mul_b_q      <= {BW{1'b0}};
            iss_vld_q    <= 1'b0;
            iss_id_q     <= {IDW{1'b0}};
            last_grant_q <= IDW'(NREQ - 1);
        end else begin
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            iss_vld_q    <= issue_s;
            iss_id_q     <= grant_id_s;
            last_grant_q <= issue_s ? grant_id_s : last_grant_q;
        end
    end

    mul_26x34_rtl #(
        .FF_IN  (FF_IN),
        .FF_MUL (FF_MUL),
        .FF_OUT (FF_OUT)
    ) u_mul (
        .clk (clk),
        .rst (~rst_n),
        .a_i (mul_a_q),
        .b_i (mul_b_q),
        .c_o (mul_c_s)
    );

    // valid/id tag pipeline tracking the multiplier latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= {LAT{1'b0}};
            for (int i = 0; i < LAT; i++) begin
                id_q[i] <= {IDW{1'b0}};
            end
        end else begin
            vld_q[0] <= iss_vld_q;
            id_q[0]  <= iss_id_q;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                id_q[i]  <= id_q[i-1];
            end
        end
    end

    // ops held in the issue stage plus the tag pipeline
    always_comb begin
        pipe_cnt_s = SW'(iss_vld_q);
        for (int i = 0; i < LAT; i++) begin
            pipe_cnt_s = pipe_cnt_s + SW'(vld_q[i]);
        end
    end

    assign push_s = vld_q[LAT-1];
    assign pop_s  = rsp_valid & rsp_ready;
    assign full_s = (cnt_q == NW'(DEPTH));

    // response storage
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_q[wr_ptr_q] <= {id_q[LAT-1], mul_c_s};
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            cnt_q    <= {NW{1'b0}};
        end else begin
            wr_ptr_q <= push_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
            rd_ptr_q <= pop_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
            case ({push_s, pop_s})
                2'b10:   cnt_q <= cnt_q + NW'(1'b1);
                2'b01:   cnt_q <= cnt_q - NW'(1'b1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // head is gated so nothing unwritten leaks out while empty or in reset
    assign head_s    = mem_q[rd_ptr_q];
    assign rsp_valid = (cnt_q != {NW{1'b0}});
    assign rsp_id    = rsp_valid ? head_s[EW-1:RW] : {IDW{1'b0}};
    assign rsp_c     = rsp_valid ? head_s[RW-1:0] : {RW{1'b0}};
    assign inflight  = (total_s > SW'(4'd15)) ? 4'd15 : total_s[3:0];

    mul_26x34_arb_chk #(
        .NREQ (NREQ)
    ) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (push_s),
        .full_i      (full_s),
        .req_ready_i (req_ready)
    );
endmodule

// File: tb/tb_mul_26x34_arb.sv
// Randomized bench for mul_26x34_arb against a transaction-level queue model.
module tb_mul_26x34_arb;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int DEPTH = 8;
    localparam int LAT   = 3;

    logic                clk = 1'b0;
    logic                rst_n = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*26-1:0]  req_a = '0;
    logic [NREQ*34-1:0]  req_b = '0;
    logic                rsp_valid;
    logic                rsp_ready = 1'b0;
    logic [IDW-1:0]      rsp_id;
    logic [59:0]         rsp_c;
    logic [3:0]          inflight;

    mul_26x34_arb #(.NREQ(NREQ), .FF_IN(1), .FF_MUL(1), .FF_OUT(1), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_c(rsp_c), .inflight(inflight)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IDW-1:0] id;
        logic [59:0]    c;
        longint         vis;
    } exp_t;

    exp_t   q[$];
    int     dut_ids[$];
    int     last_g;
    longint cyc;
    int     n_vec, n_err, n_model_acc, dut_acc, dut_pop;

    task automatic check_outputs_zero(input string tag);
        n_vec++;
        if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_c !== '0 || inflight !== 4'd0) begin
            n_err++;
            $display("FAIL %s: ready=%b valid=%b id=%0d c=%h inflight=%0d, required all zero",
                     tag, req_ready, rsp_valid, rsp_id, rsp_c, inflight);
        end
    endtask

    task automatic rand_ops();
        for (int r = 0; r < NREQ; r++) begin
            case ($urandom_range(0, 7))
                0: begin req_a[r*26 +: 26] = '1; req_b[r*34 +: 34] = '1; end
                1: begin req_a[r*26 +: 26] = '0; req_b[r*34 +: 34] = 34'($urandom); end
                default: begin
                    req_a[r*26 +: 26] = 26'($urandom);
                    req_b[r*34 +: 34] = 34'({$urandom, $urandom});
                end
            endcase
        end
    endtask

    // One clock: check outputs at the falling edge, advance the model across the rising edge.
    task automatic step();
        logic [NREQ-1:0] exp_rdy;
        logic [3:0]      exp_inf;
        logic            exp_v;
        int              gid;
        exp_t            h;
        @(negedge clk);
        exp_rdy = '0;
        gid = -1;
        if (q.size() < DEPTH) begin
            for (int k = 1; k <= NREQ; k++) begin
                int r;
                r = (last_g + k) % NREQ;
                if (gid < 0 && req_valid[r]) gid = r;
            end
        end
        if (gid >= 0) exp_rdy[gid] = 1'b1;
        n_vec++;
        if (req_ready !== exp_rdy) begin
            n_err++;
            $display("FAIL req_ready: got %b expected %b (cycle %0d)", req_ready, exp_rdy, cyc);
        end
        exp_inf = (q.size() > 15) ? 4'd15 : 4'(q.size());
        n_vec++;
        if (inflight !== exp_inf) begin
            n_err++;
            $display("FAIL inflight: got %0d expected %0d (cycle %0d)", inflight, exp_inf, cyc);
        end
        exp_v = (q.size() > 0) && (q[0].vis <= cyc);
        n_vec++;
        if (rsp_valid !== exp_v) begin
            n_err++;
            $display("FAIL rsp_valid: got %b expected %b (cycle %0d)", rsp_valid, exp_v, cyc);
        end
        if (exp_v) begin
            n_vec++;
            if (rsp_id !== q[0].id || rsp_c !== q[0].c) begin
                n_err++;
                $display("FAIL rsp_data: got id=%0d c=%h expected id=%0d c=%h (cycle %0d)",
                         rsp_id, rsp_c, q[0].id, q[0].c, cyc);
            end
        end
        for (int r = 0; r < NREQ; r++) begin
            if (req_valid[r] && req_ready[r]) begin
                dut_ids.push_back(r);
                dut_acc++;
            end
        end
        if (rsp_valid && rsp_ready) dut_pop++;
        @(posedge clk);
        cyc++;
        if (exp_v && rsp_ready) void'(q.pop_front());
        if (gid >= 0) begin
            h.id  = IDW'(gid);
            h.c   = {34'd0, req_a[gid*26 +: 26]} * {26'd0, req_b[gid*34 +: 34]};
            h.vis = cyc + LAT + 1;
            q.push_back(h);
            last_g = gid;
            n_model_acc++;
        end
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        req_valid = '0;
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        q.delete();
        dut_ids.delete();
        last_g = NREQ - 1;
    endtask

    task automatic test_reset();
        req_valid = '1;
        rsp_ready = 1'b1;
        #1 rst_n = 1'b0;
        #1 check_outputs_zero("reset_immediate");
        repeat (3) @(posedge clk);
        #1 check_outputs_zero("reset_held");
        req_valid = '0;
        rst_n = 1'b1;
        q.delete();
        last_g = NREQ - 1;
        repeat (3) step();
    endtask

    task automatic test_single_op();
        apply_reset();
        rsp_ready = 1'b1;
        req_a[2*26 +: 26] = 26'h3FFFFFF;
        req_b[2*34 +: 34] = 34'h3FFFFFFFF;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        repeat (3) step();
        n_vec++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_early: rsp_valid=%b after 3 edges, required 0", rsp_valid);
        end
        step();
        n_vec++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_c !== 60'hFFFFFFBFC000001) begin
            n_err++;
            $display("FAIL single_op: valid=%b id=%0d c=%h, required 1/2/%h",
                     rsp_valid, rsp_id, rsp_c, 60'hFFFFFFBFC000001);
        end
        repeat (4) step();
    endtask

    task automatic test_fairness();
        apply_reset();
        rsp_ready = 1'b1;
        req_valid = 4'hF;
        for (int i = 0; i < 8; i++) begin
            rand_ops();
            step();
        end
        req_valid = '0;
        n_vec++;
        if (dut_ids.size() != 8) begin
            n_err++;
            $display("FAIL fair_count: %0d grants, required 8", dut_ids.size());
        end
        for (int i = 0; i < dut_ids.size() && i < 8; i++) begin
            n_vec++;
            if (dut_ids[i] != i % NREQ) begin
                n_err++;
                $display("FAIL fair_order[%0d]: granted %0d, required %0d", i, dut_ids[i], i % NREQ);
            end
        end
        repeat (10) step();
    endtask

    task automatic test_backpressure();
        int acc0;
        apply_reset();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        acc0 = dut_acc;
        for (int i = 0; i < 12; i++) begin
            rand_ops();
            step();
        end
        n_vec++;
        if (dut_acc - acc0 != DEPTH || req_ready !== '0 || inflight !== 4'd8) begin
            n_err++;
            $display("FAIL backpressure: accepts=%0d ready=%b inflight=%0d, required 8/0000/8",
                     dut_acc - acc0, req_ready, inflight);
        end
        rsp_ready = 1'b1;
        for (int i = 0; i < 14; i++) begin
            rand_ops();
            step();
        end
        n_vec++;
        if (dut_acc - acc0 <= DEPTH) begin
            n_err++;
            $display("FAIL bp_resume: accepts=%0d after release, required more than 8", dut_acc - acc0);
        end
        req_valid = '0;
        repeat (12) step();
    endtask

    task automatic test_push_pop();
        int acc0, pop0;
        apply_reset();
        acc0 = dut_acc;
        pop0 = dut_pop;
        req_valid = 4'hF;
        for (int i = 0; i < 40; i++) begin
            rsp_ready = i[0];
            rand_ops();
            step();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (16) step();
        n_vec++;
        if (dut_pop - pop0 != dut_acc - acc0 || rsp_valid !== 1'b0 || inflight !== 4'd0) begin
            n_err++;
            $display("FAIL push_pop: pops=%0d accepts=%0d valid=%b inflight=%0d, required equal/0/0",
                     dut_pop - pop0, dut_acc - acc0, rsp_valid, inflight);
        end
    endtask

    task automatic test_reset_mid();
        int pop0;
        apply_reset();
        rsp_ready = 1'b0;
        req_valid = 4'hF;
        for (int i = 0; i < 3; i++) begin
            rand_ops();
            step();
        end
        rst_n = 1'b0;
        #1 check_outputs_zero("reset_mid");
        @(posedge clk);
        #1 rst_n = 1'b1;
        q.delete();
        last_g = NREQ - 1;
        req_valid = '0;
        rsp_ready = 1'b1;
        pop0 = dut_pop;
        repeat (10) step();
        n_vec++;
        if (dut_pop != pop0) begin
            n_err++;
            $display("FAIL reset_stale: %0d responses after release, required 0", dut_pop - pop0);
        end
    endtask

    task automatic test_random();
        int target, steps;
        apply_reset();
        target = n_model_acc + 10000;
        steps = 0;
        while (n_model_acc < target && steps < 40000) begin
            for (int r = 0; r < NREQ; r++) req_valid[r] = ($urandom_range(0, 3) != 0);
            rsp_ready = ($urandom_range(0, 3) != 0);
            rand_ops();
            step();
            steps++;
        end
        n_vec++;
        if (n_model_acc < target) begin
            n_err++;
            $display("FAIL random_budget: %0d ops short after %0d cycles", target - n_model_acc, steps);
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (20) step();
        n_vec++;
        if (rsp_valid !== 1'b0 || inflight !== 4'd0) begin
            n_err++;
            $display("FAIL random_drain: valid=%b inflight=%0d, required 0/0", rsp_valid, inflight);
        end
    endtask

    initial begin
        n_vec = 0; n_err = 0; n_model_acc = 0; dut_acc = 0; dut_pop = 0;
        cyc = 0; last_g = NREQ - 1;
        test_reset();
        test_single_op();
        test_fairness();
        test_backpressure();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
